// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types: fetch FSM states, NOP encoding, IF/ID record
package mips_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{instr: MIPS_NOP, pc4: 32'h0, valid: 1'b0};

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and flush
module if_id_reg
   import mips_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   hold,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   // flush wins over hold so a redirect during a stall still kills the wrong-path word
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= IF_ID_BUBBLE;
      end else if (flush) begin
         q <= IF_ID_BUBBLE;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS fetch stage: PC register, BOOT/RUN/HALT FSM, next-PC mux, IF/ID
// Optional FETCH_PERF_EN adds saturating fetched/stall/flush counters.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
)(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls,
   output logic [31:0] perf_flushes
`endif
);

   fetch_state_t state, state_next;
   logic [31:0]  pc_q, pc_next, pc_plus;
   logic         ifid_hold, ifid_flush;
   if_id_t       ifid_d, ifid_q;

   assign pc_plus = pc_q + PC_STEP;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = RUN;
         RUN:     state_next = halt_req ? HALT : RUN;
         HALT:    state_next = HALT;
         default: state_next = BOOT;
      endcase
   end

   // Priority inside RUN: halt_req > redirect > stall > normal advance
   always_comb begin
      pc_next    = pc_q;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b1;
      halted     = 1'b0;
      case (state)
         RUN: begin
            if (halt_req) begin
               ifid_flush = 1'b1;
            end else if (redirect) begin
               pc_next    = redirect_pc & 32'hFFFF_FFFC;
               ifid_flush = 1'b1;
            end else if (stall) begin
               ifid_flush = 1'b0;
               ifid_hold  = 1'b1;
            end else begin
               pc_next    = pc_plus;
               ifid_flush = 1'b0;
            end
         end
         HALT:    halted = 1'b1;
         default: ifid_flush = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   assign imem_pc = pc_q;

   assign ifid_d = '{instr: imem_instr, pc4: pc_plus, valid: 1'b1};

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .hold  (ifid_hold),
      .flush (ifid_flush),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign if_id_instr = ifid_q.instr;
   assign if_id_pc4   = ifid_q.pc4;
   assign if_id_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
   logic in_run, ev_fetch, ev_stall, ev_flush;

   assign in_run   = (state == RUN) && !halt_req;
   assign ev_flush = in_run && redirect;
   assign ev_stall = in_run && !redirect && stall;
   assign ev_fetch = in_run && !redirect && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= 32'h0;
         perf_stalls  <= 32'h0;
         perf_flushes <= 32'h0;
      end else begin
         if (ev_fetch) perf_fetched <= sat_inc(perf_fetched);
         if (ev_stall) perf_stalls  <= sat_inc(perf_stalls);
         if (ev_flush) perf_flushes <= sat_inc(perf_flushes);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stalls, perf_flushes;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // Instruction memory: word at byte address p is 0xA000_0000 + p
   assign imem_instr = 32'hA000_0000 + imem_pc;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .imem_pc     (imem_pc),
      .imem_instr  (imem_instr),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt_req    (halt_req),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid),
      .halted      (halted)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls),
      .perf_flushes (perf_flushes)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (imem_pc !== 32'h0) $display("FAIL reset_pc got %h exp %h", imem_pc, 32'h0); else passed++;
      total++; if (if_id_instr !== 32'h0) $display("FAIL reset_instr got %h exp %h", if_id_instr, 32'h0); else passed++;
      total++; if (if_id_pc4 !== 32'h0) $display("FAIL reset_pc4 got %h exp %h", if_id_pc4, 32'h0); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_id_valid); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
      step();
      total++; if (imem_pc !== 32'h0) $display("FAIL boot_pc got %h exp %h", imem_pc, 32'h0); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL boot_valid got %b exp 0", if_id_valid); else passed++;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      for (int i = 1; i <= 2; i++) begin
         step();
         exp_pc = 32'd4 * i;
         total++; if (imem_pc !== exp_pc) $display("FAIL seq_pc[%0d] got %h exp %h", i, imem_pc, exp_pc); else passed++;
         total++; if (if_id_pc4 !== exp_pc) $display("FAIL seq_pc4[%0d] got %h exp %h", i, if_id_pc4, exp_pc); else passed++;
         total++; if (if_id_instr !== 32'hA000_0000 + exp_pc - 32'd4)
            $display("FAIL seq_instr[%0d] got %h exp %h", i, if_id_instr, 32'hA000_0000 + exp_pc - 32'd4); else passed++;
         total++; if (if_id_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %b exp 1", i, if_id_valid); else passed++;
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (imem_pc !== 32'h8) $display("FAIL stall_pc[%0d] got %h exp %h", i, imem_pc, 32'h8); else passed++;
         total++; if (if_id_pc4 !== 32'h8) $display("FAIL stall_pc4[%0d] got %h exp %h", i, if_id_pc4, 32'h8); else passed++;
         total++; if (if_id_instr !== 32'hA000_0004) $display("FAIL stall_instr[%0d] got %h exp %h", i, if_id_instr, 32'hA000_0004); else passed++;
      end
      stall = 1'b0;
      step();
      total++; if (imem_pc !== 32'hC) $display("FAIL resume_pc got %h exp %h", imem_pc, 32'hC); else passed++;
      total++; if (if_id_pc4 !== 32'hC) $display("FAIL resume_pc4 got %h exp %h", if_id_pc4, 32'hC); else passed++;
      total++; if (if_id_instr !== 32'hA000_0008) $display("FAIL resume_instr got %h exp %h", if_id_instr, 32'hA000_0008); else passed++;
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      total++; if (imem_pc !== 32'h40) $display("FAIL redir_pc got %h exp %h", imem_pc, 32'h40); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", if_id_valid); else passed++;
      total++; if (if_id_instr !== 32'h0) $display("FAIL redir_instr got %h exp %h", if_id_instr, 32'h0); else passed++;
      step();
      total++; if (imem_pc !== 32'h44) $display("FAIL redir_next_pc got %h exp %h", imem_pc, 32'h44); else passed++;
      total++; if (if_id_pc4 !== 32'h44) $display("FAIL redir_next_pc4 got %h exp %h", if_id_pc4, 32'h44); else passed++;
      total++; if (if_id_instr !== 32'hA000_0040) $display("FAIL redir_next_instr got %h exp %h", if_id_instr, 32'hA000_0040); else passed++;
      total++; if (if_id_valid !== 1'b1) $display("FAIL redir_next_valid got %b exp 1", if_id_valid); else passed++;
   endtask

   task automatic test_redirect_stall();
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h23;
      step();
      redirect = 1'b0; stall = 1'b0;
      total++; if (imem_pc !== 32'h20) $display("FAIL rs_pc got %h exp %h", imem_pc, 32'h20); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL rs_valid got %b exp 0", if_id_valid); else passed++;
      step();
      total++; if (imem_pc !== 32'h24) $display("FAIL rs_next_pc got %h exp %h", imem_pc, 32'h24); else passed++;
      total++; if (if_id_instr !== 32'hA000_0020) $display("FAIL rs_next_instr got %h exp %h", if_id_instr, 32'hA000_0020); else passed++;
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      total++; if (imem_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_top got %h exp %h", imem_pc, 32'hFFFF_FFFC); else passed++;
      step();
      total++; if (imem_pc !== 32'h0) $display("FAIL wrap_pc got %h exp %h", imem_pc, 32'h0); else passed++;
      total++; if (if_id_pc4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp %h", if_id_pc4, 32'h0); else passed++;
      total++; if (if_id_instr !== 32'h9FFF_FFFC) $display("FAIL wrap_instr got %h exp %h", if_id_instr, 32'h9FFF_FFFC); else passed++;
   endtask

   task automatic test_halt();
      redirect = 1'b1; redirect_pc = 32'h10;
      step();
      redirect = 1'b0; halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      total++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp 1", halted); else passed++;
      total++; if (imem_pc !== 32'h10) $display("FAIL halt_pc got %h exp %h", imem_pc, 32'h10); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL halt_valid got %b exp 0", if_id_valid); else passed++;
      redirect = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
      step();
      step();
      redirect = 1'b0; stall = 1'b0;
      total++; if (imem_pc !== 32'h10) $display("FAIL halt_ignore_pc got %h exp %h", imem_pc, 32'h10); else passed++;
      total++; if (halted !== 1'b1) $display("FAIL halt_stay got %b exp 1", halted); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL halt_ignore_valid got %b exp 0", if_id_valid); else passed++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (halted !== 1'b0) $display("FAIL halt_reset_flag got %b exp 0", halted); else passed++;
      total++; if (imem_pc !== 32'h0) $display("FAIL halt_reset_pc got %h exp %h", imem_pc, 32'h0); else passed++;
      step();
      total++; if (imem_pc !== 32'h0) $display("FAIL halt_reset_boot got %h exp %h", imem_pc, 32'h0); else passed++;
      step();
      total++; if (imem_pc !== 32'h4) $display("FAIL halt_reset_run got %h exp %h", imem_pc, 32'h4); else passed++;
   endtask

   task automatic test_reset_mid_stall();
      stall = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0;
      total++; if (imem_pc !== 32'h0) $display("FAIL rst_stall_pc got %h exp %h", imem_pc, 32'h0); else passed++;
      total++; if (if_id_valid !== 1'b0) $display("FAIL rst_stall_valid got %b exp 0", if_id_valid); else passed++;
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      total++; if (perf_fetched !== 32'h0) $display("FAIL perf_reset got %0d exp 0", perf_fetched); else passed++;
      step();
      for (int i = 0; i < 10; i++) step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step();
      stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      for (int i = 0; i < 2; i++) step();
      redirect = 1'b0;
      total++; if (perf_fetched !== 32'd10) $display("FAIL perf_fetched got %0d exp 10", perf_fetched); else passed++;
      total++; if (perf_stalls !== 32'd3) $display("FAIL perf_stalls got %0d exp 3", perf_stalls); else passed++;
      total++; if (perf_flushes !== 32'd2) $display("FAIL perf_flushes got %0d exp 2", perf_flushes); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_wrap();
      test_halt();
      test_reset_mid_stall();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
